iodelay_loader: RTL and testbench

IODELAY_LOADER -- requirements
Module: iodelay_loader

---
 rtl/iodelay_pkg.sv | 21 ++
 rtl/iodelay_tap_table.sv | 78 +++++++
 rtl/iodelay_loader.sv | 158 +++++++++++++++
 tb/tb_iodelay_loader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iodelay_pkg.sv
// iodelay_pkg
// Shared widths and the FSM state type for the IODELAY tap loader.
//   TAP_W  : width of one delay tap value
//   CHAN_W : width of a channel index
//   CNT_W  : width of the PULSE/GAP down-counter (lengths are at most 15)

package iodelay_pkg;

    localparam int TAP_W  = 5;
    localparam int CHAN_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/iodelay_tap_table.sv
// iodelay_tap_table
// NCHAN x TAP_W register table holding the tap value for every delay channel.
// Writes to an index >= NCHAN are dropped. The sequencer read port is
// combinational so the loader sees the table contents of the current cycle.
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset, clears every entry
//   wr_en     : write strobe, committed on the rising clock edge
//   wr_addr   : channel index to write
//   wr_data   : tap value to write
//   seq_addr  : channel index requested by the loader FSM
//   seq_data  : tap value of seq_addr (0 when out of range)
//   rd_addr   : readback index  (only with IODELAY_LOADER_READBACK_EN)
//   rd_data   : readback value  (only with IODELAY_LOADER_READBACK_EN)
//
// Build option: IODELAY_LOADER_READBACK_EN adds the rd_addr/rd_data port.

module iodelay_tap_table
    import iodelay_pkg::*;
#(
    parameter int NCHAN = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CHAN_W-1:0] wr_addr,
    input  logic [TAP_W-1:0]  wr_data,
    input  logic [CHAN_W-1:0] seq_addr,
    output logic [TAP_W-1:0]  seq_data
`ifdef IODELAY_LOADER_READBACK_EN
    ,
    input  logic [CHAN_W-1:0] rd_addr,
    output logic [TAP_W-1:0]  rd_data
`endif
);

    logic [TAP_W-1:0] taps [NCHAN];

    // Address decode is an explicit compare per entry, so any index that
    // matches no entry (>= NCHAN) simply writes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                taps[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (wr_addr == CHAN_W'(i)) begin
                    taps[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        seq_data = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (seq_addr == CHAN_W'(i)) begin
                seq_data = taps[i];
            end
        end
    end

`ifdef IODELAY_LOADER_READBACK_EN
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_addr == CHAN_W'(i)) begin
                rd_data = taps[i];
            end
        end
    end
`else
    // No readback port in this build; the table is write-only from outside.
`endif

endmodule

// File: rtl/iodelay_loader.sv
// iodelay_loader
// Walks channels 0..NCHAN-1, presenting each channel index and its tap value
// to the delay datapath and strobing DELAY_UPDATE high for PULSE_LEN cycles
// followed by GAP_LEN low cycles, then pulses DONE.
//
// Ports
//   CLK           : system clock
//   RESET_N       : asynchronous active-low reset, aborts any sequence
//   WR_EN         : tap table write strobe
//   WR_ADDR       : tap table write channel index
//   WR_DATA       : tap value to write
//   START         : level-sampled request to program all channels
//   BUSY          : sequence in progress (SETUP through FIN)
//   DONE          : one-cycle pulse in the FIN cycle
//   DELAY_CHANNEL : channel index to the delay datapath
//   DELAY_VALUE   : tap value to the delay datapath
//   DELAY_UPDATE  : registered load strobe, high only during PULSE
//   RD_ADDR       : table readback index (IODELAY_LOADER_READBACK_EN only)
//   RD_DATA       : table readback value (IODELAY_LOADER_READBACK_EN only)
//
// Build option: IODELAY_LOADER_READBACK_EN adds RD_ADDR/RD_DATA.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; datapath outputs hold their last values
// SETUP | one cycle; latch channel index and its tap at cycle end
// PULSE | DELAY_UPDATE high for PULSE_LEN cycles
// GAP   | DELAY_UPDATE low for GAP_LEN cycles, then next channel or FIN
// FIN   | one cycle; DONE high, BUSY drops on the next cycle

module iodelay_loader
    import iodelay_pkg::*;
#(
    parameter int NCHAN     = 21,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WR_EN,
    input  logic [CHAN_W-1:0] WR_ADDR,
    input  logic [TAP_W-1:0]  WR_DATA,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [CHAN_W-1:0] DELAY_CHANNEL,
    output logic [TAP_W-1:0]  DELAY_VALUE,
    output logic              DELAY_UPDATE
`ifdef IODELAY_LOADER_READBACK_EN
    ,
    input  logic [CHAN_W-1:0] RD_ADDR,
    output logic [TAP_W-1:0]  RD_DATA
`endif
);

    localparam logic [CHAN_W-1:0] LAST_IDX   = CHAN_W'(NCHAN - 1);
    localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_LEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHAN_W-1:0] idx_q, idx_d;
    logic              load_out;
    logic [TAP_W-1:0]  tap_sel;

    iodelay_tap_table #(
        .NCHAN (NCHAN)
    ) u_table (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .wr_en    (WR_EN),
        .wr_addr  (WR_ADDR),
        .wr_data  (WR_DATA),
        .seq_addr (idx_q),
`ifdef IODELAY_LOADER_READBACK_EN
        .seq_data (tap_sel),
        .rd_addr  (RD_ADDR),
        .rd_data  (RD_DATA)
`else
        .seq_data (tap_sel)
`endif
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        load_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETUP;
                    idx_d   = '0;
                end
            end
            ST_SETUP: begin
                load_out = 1'b1;
                cnt_d    = PULSE_LOAD;
                state_d  = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + CHAN_W'(1);
                        state_d = ST_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status and strobe outputs are flops decoded from the next state, so
    // they line up exactly with the state they describe and cannot glitch.
    // The tap is latched at the end of SETUP: a write committed on that same
    // edge is not seen by this channel.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            DELAY_UPDATE  <= 1'b0;
            DELAY_CHANNEL <= '0;
            DELAY_VALUE   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            BUSY         <= (state_d != ST_IDLE);
            DONE         <= (state_d == ST_FIN);
            DELAY_UPDATE <= (state_d == ST_PULSE);
            if (load_out) begin
                DELAY_CHANNEL <= idx_q;
                DELAY_VALUE   <= tap_sel;
            end
        end
    end

endmodule

// File: tb/tb_iodelay_loader.sv
// tb_iodelay_loader
// Bench for iodelay_loader: a default-sized instance (21 channels, 4/4) and a
// single-channel instance (1 channel, 2/3). Expected tap values come from a
// table model plus a list of timed writes; a write in cycle c is visible to
// channel k only when c < k*(1+PULSE_LEN+GAP_LEN), cycle 0 being ch 0 SETUP.
// Build option: IODELAY_LOADER_READBACK_EN enables the readback checks.

module tb_iodelay_loader;

    localparam int N    = 21;
    localparam int P    = 4;
    localparam int G    = 4;
    localparam int SPAN = 1 + P + G;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, start;
    logic [7:0] wr_addr;
    logic [4:0] wr_data;
    logic       busy, done, dupd;
    logic [7:0] dch;
    logic [4:0] dval;

    logic       wr_en_s, start_s;
    logic [7:0] wr_addr_s;
    logic [4:0] wr_data_s;
    logic       busy_s, done_s, dupd_s;
    logic [7:0] dch_s;
    logic [4:0] dval_s;

`ifdef IODELAY_LOADER_READBACK_EN
    logic [7:0] rd_addr, rd_addr_s;
    logic [4:0] rd_data, rd_data_s;
`endif

    always #5 clk = ~clk;

    iodelay_loader #(.NCHAN(N), .PULSE_LEN(P), .GAP_LEN(G)) dut (
        .CLK(clk), .RESET_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_DATA(wr_data), .START(start), .BUSY(busy), .DONE(done),
        .DELAY_CHANNEL(dch), .DELAY_VALUE(dval),
`ifdef IODELAY_LOADER_READBACK_EN
        .RD_ADDR(rd_addr), .RD_DATA(rd_data),
`endif
        .DELAY_UPDATE(dupd)
    );

    iodelay_loader #(.NCHAN(1), .PULSE_LEN(2), .GAP_LEN(3)) dut_s (
        .CLK(clk), .RESET_N(rst_n), .WR_EN(wr_en_s), .WR_ADDR(wr_addr_s),
        .WR_DATA(wr_data_s), .START(start_s), .BUSY(busy_s), .DONE(done_s),
        .DELAY_CHANNEL(dch_s), .DELAY_VALUE(dval_s),
`ifdef IODELAY_LOADER_READBACK_EN
        .RD_ADDR(rd_addr_s), .RD_DATA(rd_data_s),
`endif
        .DELAY_UPDATE(dupd_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    int model [N];
    int wq_cyc[$], wq_addr[$], wq_data[$], sq_cyc[$];

    int rise_cyc[$], fall_cyc[$], rch[$], rval[$];
    int done_cyc, done_cnt, unstable, outside;
    bit timed_out;
    bit busy_hist [400];

    function automatic int exp_tap(input int k);
        int v;
        v = model[k];
        for (int i = 0; i < wq_cyc.size(); i++) begin
            if (wq_addr[i] == k && wq_cyc[i] < k * SPAN) v = wq_data[i];
        end
        return v;
    endfunction

    task automatic commit_writes();
        for (int i = 0; i < wq_cyc.size(); i++) begin
            if (wq_addr[i] < N) model[wq_addr[i]] = wq_data[i];
        end
        wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); sq_cyc.delete();
    endtask

    task automatic fill_table(input bit rnd);
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i);
            wr_data = rnd ? 5'($urandom_range(0, 31)) : 5'(i % 32);
            model[i] = int'(wr_data);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 8'($urandom_range(N, 255));
            wr_data = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    // Runs one sequence from a START pulse, applying scheduled writes/STARTs
    // at their cycle numbers and recording what the datapath port shows.
    task automatic collect(input int max_cyc);
        int c;
        bit prev;
        logic [7:0] lch;
        logic [4:0] lval;
        rise_cyc.delete(); fall_cyc.delete(); rch.delete(); rval.delete();
        done_cyc = -1; done_cnt = 0; unstable = 0; outside = 0; timed_out = 0;
        for (int i = 0; i < 400; i++) busy_hist[i] = 1'b0;
        lch = '0; lval = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev = 1'b0;
        c = 0;
        while (1) begin
            if (c >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            busy_hist[c] = busy;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (dupd === 1'b1 && busy !== 1'b1) outside++;
            if (dupd === 1'b1 && !prev) begin
                rise_cyc.push_back(c); rch.push_back(int'(dch)); rval.push_back(int'(dval));
                lch = dch; lval = dval;
            end else if (dupd === 1'b1 && (dch !== lch || dval !== lval)) begin
                unstable++;
            end
            if (dupd !== 1'b1 && prev) fall_cyc.push_back(c);
            prev = (dupd === 1'b1);
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            wr_en = 1'b0; start = 1'b0;
            foreach (wq_cyc[i]) begin
                if (wq_cyc[i] == c) begin
                    wr_en = 1'b1; wr_addr = 8'(wq_addr[i]); wr_data = 5'(wq_data[i]);
                end
            end
            foreach (sq_cyc[i]) if (sq_cyc[i] == c) start = 1'b1;
            @(negedge clk);
            c++;
        end
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic check_pulses(input string tag);
        n_cmp++;
        if (timed_out) begin
            n_err++; $display("FAIL %s_timeout: no DONE within budget", tag);
        end
        n_cmp++;
        if (rise_cyc.size() != N) begin
            n_err++; $display("FAIL %s_npulses: got %0d want %0d", tag, rise_cyc.size(), N);
        end
        for (int k = 0; k < rise_cyc.size() && k < N; k++) begin
            n_cmp++;
            if (rise_cyc[k] != k * SPAN + 1) begin
                n_err++; $display("FAIL %s_rise ch%0d: got cycle %0d want %0d", tag, k, rise_cyc[k], k * SPAN + 1);
            end
            n_cmp++;
            if (k >= fall_cyc.size() || fall_cyc[k] != rise_cyc[k] + P) begin
                n_err++; $display("FAIL %s_high_len ch%0d: got fall %0d want %0d", tag, k,
                                  (k < fall_cyc.size()) ? fall_cyc[k] : -1, rise_cyc[k] + P);
            end
            n_cmp++;
            if (rch[k] != k) begin
                n_err++; $display("FAIL %s_chan ch%0d: got %0d want %0d", tag, k, rch[k], k);
            end
            n_cmp++;
            if (rval[k] != exp_tap(k)) begin
                n_err++; $display("FAIL %s_value ch%0d: got %0d want %0d", tag, k, rval[k], exp_tap(k));
            end
        end
        n_cmp++;
        if (done_cyc != N * SPAN || done_cnt != 1) begin
            n_err++; $display("FAIL %s_done: got cycle %0d (count %0d) want cycle %0d (count 1)",
                              tag, done_cyc + 1, done_cnt, N * SPAN + 1);
        end
        n_cmp++;
        if (unstable != 0 || outside != 0) begin
            n_err++; $display("FAIL %s_stability: got %0d unstable / %0d outside want 0/0", tag, unstable, outside);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 0; start = 0; wr_addr = 0; wr_data = 0;
        wr_en_s = 0; start_s = 0; wr_addr_s = 0; wr_data_s = 0;
`ifdef IODELAY_LOADER_READBACK_EN
        rd_addr = 0; rd_addr_s = 0;
`endif
        for (int i = 0; i < N; i++) model[i] = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, dupd} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got busy/done/upd %b want 000", {busy, done, dupd});
        end
        n_cmp++;
        if (dch !== 8'd0 || dval !== 5'd0) begin
            n_err++; $display("FAIL reset_outputs: got ch %0d val %0d want 0 0", dch, dval);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d;
        fill_table(1'b0);
        collect(400);
        check_pulses("basic");
        d = (done_cyc < 0) ? 0 : done_cyc;
        n_cmp++;
        if (busy_hist[0] !== 1'b1 || busy_hist[d + 1] !== 1'b0) begin
            n_err++; $display("FAIL basic_busy: got first %b after %b want 1 0", busy_hist[0], busy_hist[d + 1]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (int'(dch) != N - 1 || int'(dval) != exp_tap(N - 1)) begin
            n_err++; $display("FAIL idle_hold: got ch %0d val %0d want %0d %0d", dch, dval, N - 1, exp_tap(N - 1));
        end
        commit_writes();
    endtask

    task automatic test_start_while_busy();
        int d;
        sq_cyc.push_back(3); sq_cyc.push_back(50); sq_cyc.push_back(N * SPAN);
        collect(400);
        check_pulses("busy_start");
        d = (done_cyc < 0) ? 0 : done_cyc;
        n_cmp++;
        if (busy_hist[d + 1] !== 1'b0 || busy_hist[d + 2] !== 1'b0) begin
            n_err++; $display("FAIL busy_start_no_second: got busy %b%b after DONE want 00", busy_hist[d + 1], busy_hist[d + 2]);
        end
        commit_writes();
    endtask

    task automatic test_midseq_writes();
        wq_cyc.push_back(3 * SPAN);      wq_addr.push_back(3);  wq_data.push_back(7);
        wq_cyc.push_back(15 * SPAN - 1); wq_addr.push_back(15); wq_data.push_back(31);
        collect(400);
        check_pulses("midseq");
        n_cmp++;
        if (rval.size() > 15 && rval[15] != 31) begin
            n_err++; $display("FAIL midseq_ch15: got %0d want 31", rval[15]);
        end
        n_cmp++;
        if (rval.size() > 3 && rval[3] != model[3]) begin
            n_err++; $display("FAIL midseq_ch3: got %0d want %0d", rval[3], model[3]);
        end
        commit_writes();
    endtask

    task automatic test_random();
        int cyc;
        for (int it = 0; it < 2; it++) begin
            fill_table(1'b1);
            cyc = 0;
            for (int w = 0; w < 12; w++) begin
                cyc = cyc + $urandom_range(1, 15);
                wq_cyc.push_back(cyc);
                wq_addr.push_back($urandom_range(0, 3) == 0 ? $urandom_range(N, 255) : $urandom_range(0, N - 1));
                wq_data.push_back($urandom_range(0, 31));
            end
            sq_cyc.push_back($urandom_range(1, 180));
            collect(400);
            check_pulses("random");
            commit_writes();
        end
    endtask

    task automatic test_back_to_back();
        int d;
        sq_cyc.push_back(N * SPAN); sq_cyc.push_back(N * SPAN + 1);
        collect(400);
        d = (done_cyc < 0) ? 0 : done_cyc;
        n_cmp++;
        if (done_cyc != N * SPAN || busy_hist[d + 1] !== 1'b0 || busy_hist[d + 2] !== 1'b1) begin
            n_err++; $display("FAIL back_to_back: got done %0d busy %b%b want %0d 01",
                              done_cyc, busy_hist[d + 1], busy_hist[d + 2], N * SPAN);
        end
        commit_writes();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) model[i] = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_midseq();
        int dseen;
        fill_table(1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9 * SPAN + 2) @(negedge clk);
        n_cmp++;
        if (dupd !== 1'b1 || dch !== 8'd9) begin
            n_err++; $display("FAIL rstmid_in_pulse: got upd %b ch %0d want 1 9", dupd, dch);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, dupd} !== 3'b000 || dch !== 8'd0 || dval !== 5'd0) begin
            n_err++; $display("FAIL rstmid_outputs: got b/d/u %b ch %0d val %0d want 000 0 0", {busy, done, dupd}, dch, dval);
        end
        dseen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) dseen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dseen++;
        end
        n_cmp++;
        if (dseen != 0) begin
            n_err++; $display("FAIL rstmid_no_done: got %0d DONE/BUSY cycles want 0", dseen);
        end
        for (int i = 0; i < N; i++) model[i] = 0;
        collect(400);
        check_pulses("rstmid_table");
        commit_writes();
    endtask

    task automatic test_small();
        int rise, fall, dc, nr, ch, val;
        bit prev;
        bit bh [30];
        wr_en_s = 1'b1; wr_addr_s = 8'd0; wr_data_s = 5'd12;
        @(negedge clk);
        wr_addr_s = 8'd1; wr_data_s = 5'd9;
        @(negedge clk);
        wr_en_s = 1'b0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        rise = -1; fall = -1; dc = -1; nr = 0; ch = -1; val = -1; prev = 0;
        for (int c = 0; c < 30; c++) begin
            bh[c] = busy_s;
            if (done_s === 1'b1 && dc < 0) dc = c;
            if (dupd_s === 1'b1 && !prev) begin
                nr++; rise = c; ch = int'(dch_s); val = int'(dval_s);
            end
            if (dupd_s !== 1'b1 && prev && fall < 0) fall = c;
            prev = (dupd_s === 1'b1);
            @(negedge clk);
        end
        n_cmp++;
        if (nr != 1 || rise != 1 || fall != 3) begin
            n_err++; $display("FAIL small_pulse: got %0d pulses rise %0d fall %0d want 1 1 3", nr, rise, fall);
        end
        n_cmp++;
        if (ch != 0 || val != 12) begin
            n_err++; $display("FAIL small_value: got ch %0d val %0d want 0 12", ch, val);
        end
        n_cmp++;
        if (dc != 6 || bh[0] !== 1'b1 || bh[7] !== 1'b0) begin
            n_err++; $display("FAIL small_done: got done cycle %0d busy %b/%b want 7 1/0", dc + 1, bh[0], bh[7]);
        end
    endtask

`ifdef IODELAY_LOADER_READBACK_EN
    task automatic test_readback();
        int a;
        wr_en = 1'b1; wr_addr = 8'd20; wr_data = 5'd17;
        @(negedge clk);
        wr_en = 1'b0;
        model[20] = 17;
        rd_addr = 8'd20;
        #1;
        n_cmp++;
        if (rd_data !== 5'd17) begin
            n_err++; $display("FAIL readback_20: got %0d want 17", rd_data);
        end
        rd_addr = 8'd200;
        #1;
        n_cmp++;
        if (rd_data !== 5'd0) begin
            n_err++; $display("FAIL readback_200: got %0d want 0", rd_data);
        end
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(0, 40);
            rd_addr = 8'(a);
            #1;
            n_cmp++;
            if (int'(rd_data) != ((a < N) ? model[a] : 0)) begin
                n_err++; $display("FAIL readback_rand addr %0d: got %0d want %0d", a, rd_data, (a < N) ? model[a] : 0);
            end
        end
        rd_addr_s = 8'd1;
        #1;
        n_cmp++;
        if (rd_data_s !== 5'd0) begin
            n_err++; $display("FAIL readback_small_1: got %0d want 0", rd_data_s);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_start_while_busy();
        test_midseq_writes();
        test_random();
        test_back_to_back();
        test_reset_midseq();
        test_small();
`ifdef IODELAY_LOADER_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
